// File: rtl/cmp_flag_pkg.sv
// Shared definitions for the compare-flag monitor: flag bit positions,
// invariant indices and the run-control state encoding.
package cmp_flag_pkg;

  localparam int NUM_FLAGS = 8;

  localparam int FLAG_EQ       = 7;
  localparam int FLAG_NEQ      = 6;
  localparam int FLAG_LT       = 5;
  localparam int FLAG_LE       = 4;
  localparam int FLAG_GT       = 3;
  localparam int FLAG_GE       = 2;
  localparam int FLAG_CASE_EQ  = 1;
  localparam int FLAG_CASE_NEQ = 0;

  localparam int I_EQ_NEQ    = 0;
  localparam int I_LT_GE     = 1;
  localparam int I_GT_LE     = 2;
  localparam int I_LE_DEF    = 3;
  localparam int I_GE_DEF    = 4;
  localparam int I_CASE_PAIR = 5;
  localparam int I_CASE_EQ   = 6;
  localparam int I_ONE_HOT   = 7;

  // Field order mirrors the bit order of the flag vector (eq is the MSB).
  typedef struct packed {
    logic eq;
    logic neq;
    logic lt;
    logic le;
    logic gt;
    logic ge;
    logic case_eq;
    logic case_neq;
  } flag_vec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mon_state_t;

endpackage

// File: rtl/cmp_flag_checker.sv
// Combinational consistency check of one compare-flag vector; bit i of v
// is set when invariant i does not hold.
module cmp_flag_checker
  import cmp_flag_pkg::*;
(
  input  logic [NUM_FLAGS-1:0] flags,
  output logic [NUM_FLAGS-1:0] v
);

  flag_vec_t f;
  logic      one_hot;

  assign f = flag_vec_t'(flags);

  // Exactly one of three: odd parity but not all three set.
  assign one_hot = (f.lt ^ f.eq ^ f.gt) & ~(f.lt & f.eq & f.gt);

  always_comb begin
    v              = '0;
    v[I_EQ_NEQ]    = ~(f.eq ^ f.neq);
    v[I_LT_GE]     = ~(f.lt ^ f.ge);
    v[I_GT_LE]     = ~(f.gt ^ f.le);
    v[I_LE_DEF]    = f.le ^ (f.lt | f.eq);
    v[I_GE_DEF]    = f.ge ^ (f.gt | f.eq);
    v[I_CASE_PAIR] = ~(f.case_eq ^ f.case_neq);
    v[I_CASE_EQ]   = f.case_eq ^ f.eq;
    v[I_ONE_HOT]   = ~one_hot;
  end

endmodule

// File: rtl/cmp_flag_monitor.sv
// Run-based monitor for the compare-flag stream: counts samples and
// violations, captures the first failing beat and folds every beat into a MISR.
module cmp_flag_monitor
  import cmp_flag_pkg::*;
#(
  parameter int              CNT_W    = 16,
  parameter int              SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(16'h1021),
  parameter logic [SIG_W-1:0] SIG_SEED = '1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_samples,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_FLAGS-1:0] flags,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     sample_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [NUM_FLAGS-1:0] err_mask,
  output logic [NUM_FLAGS-1:0] first_err_flags,
  output logic [CNT_W-1:0]     first_err_idx,
  output logic [SIG_W-1:0]     signature
);

  mon_state_t           state_q, state_d;
  logic [CNT_W-1:0]     num_q, num_d;
  logic [CNT_W-1:0]     sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
  logic [NUM_FLAGS-1:0] err_mask_q, err_mask_d;
  logic [NUM_FLAGS-1:0] first_flags_q, first_flags_d;
  logic [CNT_W-1:0]     first_idx_q, first_idx_d;
  logic [SIG_W-1:0]     sig_q, sig_d;

  logic [NUM_FLAGS-1:0] viol;
  logic [CNT_W-1:0]     cnt_inc;
  logic [SIG_W-1:0]     sig_next;
  logic                 accept;

  cmp_flag_checker u_checker (
    .flags (flags),
    .v     (viol)
  );

  // start wins over a coincident beat, so it also closes the ready window.
  assign in_ready = (state_q == RUN) & ~start;
  assign accept   = in_valid & in_ready;
  assign cnt_inc  = sample_cnt_q + CNT_W'(1);

  assign sig_next = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? SIG_POLY : '0)
                  ^ SIG_W'(flags);

  always_comb begin
    state_d       = state_q;
    num_d         = num_q;
    sample_cnt_d  = sample_cnt_q;
    err_cnt_d     = err_cnt_q;
    err_mask_d    = err_mask_q;
    first_flags_d = first_flags_q;
    first_idx_d   = first_idx_q;
    sig_d         = sig_q;

    if (start) begin
      num_d         = num_samples;
      sample_cnt_d  = '0;
      err_cnt_d     = '0;
      err_mask_d    = '0;
      first_flags_d = '0;
      first_idx_d   = '0;
      sig_d         = SIG_SEED;
      state_d       = (num_samples == '0) ? DONE : RUN;
    end else if (accept) begin
      sample_cnt_d = cnt_inc;
      sig_d        = sig_next;
      if (viol != '0) begin
        if (err_cnt_q == '0) begin
          first_flags_d = flags;
          first_idx_d   = sample_cnt_q;
        end
        if (err_cnt_q != '1)
          err_cnt_d = err_cnt_q + CNT_W'(1);
        err_mask_d = err_mask_q | viol;
      end
      if (cnt_inc == num_q)
        state_d = DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      num_q         <= '0;
      sample_cnt_q  <= '0;
      err_cnt_q     <= '0;
      err_mask_q    <= '0;
      first_flags_q <= '0;
      first_idx_q   <= '0;
      sig_q         <= SIG_SEED;
    end else begin
      state_q       <= state_d;
      num_q         <= num_d;
      sample_cnt_q  <= sample_cnt_d;
      err_cnt_q     <= err_cnt_d;
      err_mask_q    <= err_mask_d;
      first_flags_q <= first_flags_d;
      first_idx_q   <= first_idx_d;
      sig_q         <= sig_d;
    end
  end

  assign busy            = (state_q == RUN);
  assign done            = (state_q == DONE);
  assign sample_cnt      = sample_cnt_q;
  assign err_cnt         = err_cnt_q;
  assign err_mask        = err_mask_q;
  assign first_err_flags = first_flags_q;
  assign first_err_idx   = first_idx_q;
  assign signature       = sig_q;

endmodule

// File: doc/cmp_flag_monitor.md
Name: cmp_flag_monitor

Overview:
- Sequential stage directly downstream of the constant-compare block. It consumes that block's 8-bit flag vector, bit 7..0 = eq, neq, lt, le, gt, ge, case_eq, case_neq.
- Over a run of N accepted samples it:
  - checks the logical consistency of each flag vector;
  - counts samples and violations;
  - captures the first failing vector;
  - compresses every vector into a MISR signature for fuzz-run comparison.

Parameters:
- CNT_W, 16: width of sample/error counters and of num_samples.
- SIG_W, 16: MISR width; must be ≥ 8.
- SIG_POLY, 16'h1021: MISR feedback polynomial (low SIG_W bits used).
- SIG_SEED, all-ones: MISR value loaded on start.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: clear results, load seed, begin run.
- num_samples  in  CNT_W  run length; sampled on start.
- in_valid  in  1  flag vector valid.
- in_ready  out  1  monitor accepts a beat this cycle.
- flags  in  8  flag vector from the compare stage.
- busy  out  1  state == RUN.
- done  out  1  state == DONE; level, held until the next start.
- sample_cnt  out  CNT_W  accepted beats in the current run.
- err_cnt  out  CNT_W  beats with at least one violation; saturating.
- err_mask  out  8  sticky OR of per-invariant violations.
- first_err_flags  out  8  flags of the first failing beat.
- first_err_idx  out  CNT_W  sample_cnt value at the first failing beat.
- signature  out  SIG_W  MISR value.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; all outputs 0, except signature = SIG_SEED.
- States:
  - IDLE: in_ready=0.
  - On start: latch num_samples, clear counters/mask/capture, load SIG_SEED.
  - Then go to RUN, or to DONE if num_samples == 0 (DONE follows the next edge with all counts 0).
  - RUN: in_ready = ~start. A beat is accepted when in_valid & in_ready.
  - The beat that makes sample_cnt == num_samples moves to DONE on the same edge.
  - DONE: in_ready=0; results stable until start.
- start in any state, including mid-RUN: restarts the run. start has priority, so a coincident beat is dropped and not counted.
- Invariants (bit i of the violation vector v is set when invariant i fails):
  - I0: eq != neq
  - I1: lt != ge
  - I2: gt != le
  - I3: le == (lt | eq)
  - I4: ge == (gt | eq)
  - I5: case_eq != case_neq
  - I6: case_eq == eq
  - I7: exactly one of {lt, eq, gt}
- Per accepted beat, with all updates visible the cycle after acceptance (latency 1):
  - sample_cnt += 1.
  - If v != 0:
    - err_cnt += 1, saturating at all-ones;
    - err_mask |= v;
    - if err_cnt was 0, capture first_err_flags = flags and first_err_idx = pre-increment sample_cnt.
  - signature = {sig[SIG_W-2:0],0} ^ (sig[SIG_W-1] ? SIG_POLY : 0) ^ zero-extend(flags).
- Non-accepted cycles change nothing. flags are ignored when the beat is not accepted.
- sample_cnt never wraps: RUN ends when it reaches num_samples.

Decomposition:
- Package cmp_flag_pkg holds:
  - flag bit index constants: FLAG_EQ=7 … FLAG_CASE_NEQ=0;
  - invariant index constants I_EQ_NEQ=0 … I_ONE_HOT=7;
  - enum mon_state_t {IDLE, RUN, DONE}.
- One sub-module, cmp_flag_checker: purely combinational, flags[7:0] → v[7:0]. It is reusable by the testbench scoreboard.
- The MISR stays inline.

Test Plan:
- Reset, then idle: done=0, busy=0, in_ready=0, signature=16'hFFFF, all counters 0.
- Start, num_samples=3, beats 0x96, 0x71, 0x4D (eq, lt, gt cases) → done one cycle after beat 3; sample_cnt=3, err_cnt=0, err_mask=0. After beat 1 alone, signature=16'hEF49.
- Start, num_samples=4, beats 0x96, 0xFF, 0x00, 0x71 → err_cnt=2, first_err_flags=0xFF, first_err_idx=1, err_mask ⊇ 0xA7 (0xFF alone gives 0xA7).
- in_valid toggled randomly, with a start pulse mid-run coincident with a valid beat → that beat is not counted; counters restart from 0; final sample_cnt equals num_samples.
- num_samples=0 → done one cycle after start; no beats accepted; signature=SIG_SEED.
- rst_n asserted mid-RUN (asynchronous, between edges) → outputs go to reset values immediately; the next start runs normally.
